pipe_control_unit: RTL

- Pipelined successor to the combinational MIPS decoder. Decodes opcode/function in ID and registers the control bundle through ID/EX, EX/MEM and MEM/WB.
- Integrates load-use hazard detection with bubble insertion, and flush on jump or taken branch.
- Branch-resolution stage is parametrised.
- Sits between the IF/ID register and the datapath; drives stage-local control directly.

---
 rtl/pipe_control_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined MIPS control with load-use stall and jump/branch flush.
// Define PIPE_CTRL_PERF_EN to add saturating stallCount/flushCount outputs.
module pipe_control_unit #(
    parameter int FUNC_W       = 6,
    parameter int REG_W        = 5,
    parameter int BRANCH_STAGE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FUNC_W-1:0] inOpcode,
    input  logic [FUNC_W-1:0] inFunction,
    input  logic [REG_W-1:0]  inRs,
    input  logic [REG_W-1:0]  inRt,
    input  logic              inBranchTaken,
    output logic              stall,
    output logic              flushIFID,
    output logic              jumpID,
    output logic [1:0]        exRegDst,
    output logic              exALUSrc,
    output logic [1:0]        exALUOp,
    output logic [FUNC_W-1:0] exFunction,
    output logic [REG_W-1:0]  exRt,
    output logic              memBranch,
    output logic              memFlagBranch,
    output logic              memRead,
    output logic              memWrite,
    output logic [2:0]        memLoadDiv,
    output logic [1:0]        memStoreDiv,
    output logic              wbRegWrite,
    output logic [1:0]        wbMemtoReg
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       stallCount,
    output logic [31:0]       flushCount
`endif
);
    localparam logic [FUNC_W-1:0] OP_R = 0, OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5;
    localparam logic [FUNC_W-1:0] OP_LB = 32, OP_LH = 33, OP_LW = 35, OP_LBU = 36, OP_LHU = 37, OP_LWU = 39;
    localparam logic [FUNC_W-1:0] OP_SB = 40, OP_SH = 41, OP_SW = 43;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } wb_t;

    typedef struct packed {
        logic       branch;
        logic       flag_branch;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] load_div;
        logic [1:0] store_div;
        wb_t        wb;
    } mem_t;

    typedef struct packed {
        logic [1:0]        reg_dst;
        logic              alu_src;
        logic [1:0]        alu_op;
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rt;
        mem_t              mem;
    } ex_t;

    ex_t  id_ctrl, id_ex;
    mem_t ex_mem;
    wb_t  mem_wb;
    logic is_r, is_load, is_store, is_br, is_imm, uses_rs, uses_rt, hazard, taken;

    assign is_r     = inOpcode == OP_R;
    assign is_load  = inOpcode inside {OP_LW, OP_LWU, OP_LB, OP_LBU, OP_LH, OP_LHU};
    assign is_store = inOpcode inside {OP_SW, OP_SB, OP_SH};
    assign is_br    = inOpcode inside {OP_BEQ, OP_BNE};
    assign jumpID   = inOpcode inside {OP_J, OP_JAL};
    assign is_imm   = !(is_r || is_load || is_store || is_br || jumpID);
    assign uses_rt  = is_r || is_br || is_store;
    assign uses_rs  = !jumpID;

    always_comb begin
        id_ctrl                    = '0;
        id_ctrl.reg_dst            = inOpcode == OP_JAL ? 2'd2 : is_r ? 2'd1 : 2'd0;
        id_ctrl.alu_src            = is_load || is_store || is_imm;
        id_ctrl.alu_op             = is_r ? 2'b10 : is_br ? 2'b01 : is_imm ? 2'b11 : 2'b00;
        id_ctrl.func               = is_r ? inFunction : inOpcode;
        id_ctrl.rt                 = inRt;
        id_ctrl.mem.branch         = is_br;
        id_ctrl.mem.flag_branch    = inOpcode == OP_BEQ;
        id_ctrl.mem.mem_read       = is_load;
        id_ctrl.mem.mem_write      = is_store;
        id_ctrl.mem.load_div       = inOpcode == OP_LWU ? 3'd1 : inOpcode == OP_LB ? 3'd2 :
                                     inOpcode == OP_LBU ? 3'd3 : inOpcode == OP_LH ? 3'd4 :
                                     inOpcode == OP_LHU ? 3'd5 : 3'd0;
        id_ctrl.mem.store_div      = inOpcode == OP_SB ? 2'd1 : inOpcode == OP_SH ? 2'd2 : 2'd0;
        id_ctrl.mem.wb.reg_write   = is_r || is_load || is_imm || inOpcode == OP_JAL;
        id_ctrl.mem.wb.mem_to_reg  = inOpcode == OP_JAL ? 2'd2 : is_load ? 2'd1 : 2'd0;
    end

    assign hazard = id_ex.mem.mem_read && id_ex.rt != '0 &&
                    ((uses_rs && id_ex.rt == inRs) || (uses_rt && id_ex.rt == inRt));
    assign taken  = inBranchTaken && (BRANCH_STAGE == 1 ? id_ex.mem.branch : ex_mem.branch);
    // a taken branch squashes the stalled instruction anyway, so it overrides the stall
    assign stall     = hazard && !taken;
    assign flushIFID = taken || (jumpID && !stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= (stall || taken) ? '0 : id_ctrl;
            ex_mem <= (taken && BRANCH_STAGE == 2) ? '0 : id_ex.mem;
            mem_wb <= ex_mem.wb;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            stallCount <= stallCount + 32'(stall && !(&stallCount));
            flushCount <= flushCount + 32'(flushIFID && !(&flushCount));
        end
    end
`endif

    assign exRegDst      = id_ex.reg_dst;
    assign exALUSrc      = id_ex.alu_src;
    assign exALUOp       = id_ex.alu_op;
    assign exFunction    = id_ex.func;
    assign exRt          = id_ex.rt;
    assign memBranch     = ex_mem.branch;
    assign memFlagBranch = ex_mem.flag_branch;
    assign memRead       = ex_mem.mem_read;
    assign memWrite      = ex_mem.mem_write;
    assign memLoadDiv    = ex_mem.load_div;
    assign memStoreDiv   = ex_mem.store_div;
    assign wbRegWrite    = mem_wb.reg_write;
    assign wbMemtoReg    = mem_wb.mem_to_reg;
endmodule
